// File: rtl/jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter
//
// Purpose:
//   Shared bank of NBITS master-slave JK storage cells. NREQ requesters each
//   present one J/K command aimed at one cell. A round-robin arbiter picks one
//   command at a time, and a three-state sequencer applies it:
//     IDLE   : arbitrate and capture the winning command
//     MASTER : evaluate the JK rule against the visible cell value into the
//              master stage (gnt pulse to the winner during this cycle)
//     SLAVE  : transfer the master value to the visible slave (q)
//   Every command occupies exactly three cycles. This block is the only writer
//   of JK cell state in the flip-flop subsystem.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   req      in   [NREQ]       per-requester level request
//   idx      in   [NREQ*IDXW]  per-requester target cell, r at [r*IDXW +: IDXW]
//   jk       in   [NREQ*2]     per-requester {J,K}, r at [r*2 +: 2]
//   gnt      out  [NREQ]       one-hot grant, single-cycle pulse (registered)
//   busy     out               command in flight (combinational from state)
//   done     out               single-cycle completion pulse (registered)
//   done_id  out  [RIDW]       requester id of the completed command
//   err      out               with done: target index was out of range and
//                              the command was dropped
//   q        out  [NBITS]      visible (slave) value of every cell
// -----------------------------------------------------------------------------
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3,
    parameter int RIDW  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*IDXW-1:0]   idx,
    input  logic [NREQ*2-1:0]      jk,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   done,
    output logic [RIDW-1:0]        done_id,
    output logic                   err,
    output logic [NBITS-1:0]       q
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MASTER = 2'd1,
        ST_SLAVE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic jk_eval(input logic [1:0] cmd, input logic cur);
        logic nxt;
        case (cmd)
            2'b00:   nxt = cur;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11:   nxt = ~cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // First set request at or above ptr, wrapping modulo NREQ.
    function automatic logic [RIDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [RIDW-1:0] ptr);
        logic [RIDW-1:0] w;
        logic            found;
        int              c;
        w     = {RIDW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c = (int'(ptr) + i) % NREQ;
            if (!found && r[c]) begin
                w     = RIDW'(c);
                found = 1'b1;
            end else begin
                w     = w;
                found = found;
            end
        end
        return w;
    endfunction

    // One-hot cell select; an index at or beyond NBITS decodes to all zeros,
    // so an out-of-range command cannot disturb any cell.
    function automatic logic [NBITS-1:0] cell_decode(input logic [IDXW-1:0] i);
        logic [NBITS-1:0] dec;
        for (int b = 0; b < NBITS; b++) begin
            dec[b] = (32'(i) == 32'(b));
        end
        return dec;
    endfunction

    // Binary requester id to one-hot grant vector.
    function automatic logic [NREQ-1:0] id_onehot(input logic [RIDW-1:0] w);
        logic [NREQ-1:0] oh;
        for (int r = 0; r < NREQ; r++) begin
            oh[r] = (32'(w) == 32'(r));
        end
        return oh;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q,   state_d;
    logic [NBITS-1:0]  q_q,       q_d;
    logic [NBITS-1:0]  master_q,  master_d;
    logic [RIDW-1:0]   rr_q,      rr_d;
    logic [RIDW-1:0]   win_q,     win_d;
    logic [IDXW-1:0]   idx_q,     idx_d;
    logic [1:0]        jk_q,      jk_d;
    logic              errf_q,    errf_d;
    logic [NREQ-1:0]   gnt_q,     gnt_d;
    logic              done_q,    done_d;
    logic [RIDW-1:0]   done_id_q, done_id_d;
    logic              err_q,     err_d;

    // Combinational helpers
    logic [RIDW-1:0]   pick_s;
    logic [NBITS-1:0]  sel_s;
    logic              in_range_s;
    logic              cur_bit_s;
    logic              new_bit_s;

    // Arbitration result for the current request vector and pointer.
    assign pick_s     = rr_pick(req, rr_q);
    // Decoded target cell of the captured command.
    assign sel_s      = cell_decode(idx_q);
    assign in_range_s = (32'(idx_q) < 32'(NBITS));
    // Visible value of the target cell (0 when out of range; unused then).
    assign cur_bit_s  = |(q_q & sel_s);
    assign new_bit_s  = jk_eval(jk_q, cur_bit_s);

    // Next-state and datapath logic for the three-state sequencer.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        master_d  = master_q;
        rr_d      = rr_q;
        win_d     = win_q;
        idx_d     = idx_q;
        jk_d      = jk_q;
        errf_d    = errf_q;
        gnt_d     = {NREQ{1'b0}};
        done_d    = 1'b0;
        done_id_d = {RIDW{1'b0}};
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    win_d   = pick_s;
                    idx_d   = idx[int'(pick_s)*IDXW +: IDXW];
                    jk_d    = jk[int'(pick_s)*2 +: 2];
                    errf_d  = 1'b0;
                    // Registered here so the pulse lines up with MASTER.
                    gnt_d   = id_onehot(pick_s);
                    state_d = ST_MASTER;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MASTER: begin
                // sel_s is all zeros out of range, so master holds then.
                master_d = (master_q & ~sel_s) | (sel_s & {NBITS{new_bit_s}});
                errf_d   = ~in_range_s;
                state_d  = ST_SLAVE;
            end

            ST_SLAVE: begin
                if (!errf_q) begin
                    q_d = (q_q & ~sel_s) | (master_q & sel_s);
                end else begin
                    q_d = q_q;
                end
                done_d    = 1'b1;
                done_id_d = win_q;
                err_d     = errf_q;
                // Pointer moves past the winner whether or not it errored.
                rr_d      = RIDW'((int'(win_q) + 1) % NREQ);
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            q_q       <= {NBITS{1'b0}};
            master_q  <= {NBITS{1'b0}};
            rr_q      <= {RIDW{1'b0}};
            win_q     <= {RIDW{1'b0}};
            idx_q     <= {IDXW{1'b0}};
            jk_q      <= 2'b00;
            errf_q    <= 1'b0;
            gnt_q     <= {NREQ{1'b0}};
            done_q    <= 1'b0;
            done_id_q <= {RIDW{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            master_q  <= master_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            idx_q     <= idx_d;
            jk_q      <= jk_d;
            errf_q    <= errf_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;
    assign q       = q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 6;
    localparam int IDXW  = 3;
    localparam int RIDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ*2-1:0]    jk;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic                 done;
    logic [RIDW-1:0]      done_id;
    logic                 err;
    logic [NBITS-1:0]     q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW), .RIDW(RIDW)) dut (
        .clk(clk), .reset(reset), .req(req), .idx(idx), .jk(jk),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .err(err), .q(q)
    );

    // Reference model state (transaction view: bank contents, pointer, and
    // how many cycles of the current command remain).
    logic [NBITS-1:0] mq;
    int               mptr;
    int               mleft;
    int               mw;
    int               midx;
    logic [1:0]       mjk;
    logic             mnew;
    logic             merr;
    logic [NREQ-1:0]  exp_gnt;
    logic             exp_done;
    int               exp_id;
    logic             exp_err;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int r, input int i, input logic [1:0] c);
        idx[r*IDXW +: IDXW] = IDXW'(i);
        jk[r*2 +: 2]        = c;
    endtask

    task automatic do_reset;
        req   = '0;
        idx   = '0;
        jk    = '0;
        reset = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
    endtask

    // Predict what the next rising edge produces, from the inputs present now.
    task automatic model_step;
        bit found;
        int c;
        exp_gnt  = '0;
        exp_done = 1'b0;
        exp_id   = 0;
        exp_err  = 1'b0;
        if (mleft == 0) begin
            if (req != '0) begin
                found = 0;
                for (int i = 0; i < NREQ; i++) begin
                    c = (mptr + i) % NREQ;
                    if (!found && req[c]) begin
                        mw = c;
                        found = 1;
                    end
                end
                midx        = int'(idx[mw*IDXW +: IDXW]);
                mjk         = jk[mw*2 +: 2];
                exp_gnt[mw] = 1'b1;
                mleft       = 2;
            end
        end else if (mleft == 2) begin
            if (midx < NBITS) begin
                case (mjk)
                    2'b00:   mnew = mq[midx];
                    2'b01:   mnew = 1'b0;
                    2'b10:   mnew = 1'b1;
                    default: mnew = !mq[midx];
                endcase
                merr = 1'b0;
            end else begin
                merr = 1'b1;
            end
            mleft = 1;
        end else begin
            if (!merr) mq[midx] = mnew;
            exp_done = 1'b1;
            exp_id   = mw;
            exp_err  = merr;
            mptr     = (mw + 1) % NREQ;
            mleft    = 0;
        end
    endtask

    task automatic test_reset;
        req = '0; idx = '0; jk = '0;
        reset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (done_id !== 2'd0) begin failures++; $display("FAIL reset_done_id got=%0d exp=0", done_id); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (q !== 6'h00) begin failures++; $display("FAIL reset_q got=%h exp=%h", q, 6'h00); end
        tick();
        #2 reset = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        set_cmd(1, 3, 2'b10);
        req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0010); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_m got=%b exp=1", busy); end
        checks++; if (q !== 6'h00) begin failures++; $display("FAIL single_q_early got=%h exp=%h", q, 6'h00); end
        req = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (q !== 6'h00) begin failures++; $display("FAIL single_q_master got=%h exp=%h", q, 6'h00); end
        tick();
        checks++; if (q !== 6'h08) begin failures++; $display("FAIL single_q got=%h exp=%h", q, 6'h08); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", done); end
        checks++; if (done_id !== 2'd1) begin failures++; $display("FAIL single_done_id got=%0d exp=1", done_id); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_toggle;
        do_reset();
        set_cmd(0, 0, 2'b11);
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL toggle_gnt1 got=%b exp=%b", gnt, 4'b0001); end
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL toggle_gap1 got=%b exp=%b", gnt, 4'b0000); end
        tick();
        checks++; if (q !== 6'h01) begin failures++; $display("FAIL toggle_q1 got=%h exp=%h", q, 6'h01); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL toggle_gap2 got=%b exp=%b", gnt, 4'b0000); end
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL toggle_gnt2 got=%b exp=%b", gnt, 4'b0001); end
        req = 4'b0000;
        tick();
        tick();
        checks++; if (q !== 6'h00) begin failures++; $display("FAIL toggle_q2 got=%h exp=%h", q, 6'h00); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL toggle_done2 got=%b exp=1", done); end
    endtask

    task automatic test_all_four;
        logic [NREQ-1:0] want;
        do_reset();
        for (int r = 0; r < NREQ; r++) set_cmd(r, r, 2'b10);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            want = '0;
            want[k] = 1'b1;
            tick();
            checks++; if (gnt !== want) begin failures++; $display("FAIL all4_gnt%0d got=%b exp=%b", k, gnt, want); end
            tick();
            checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL all4_gap%0d got=%b exp=%b", k, gnt, 4'b0000); end
            tick();
            checks++; if (done_id !== RIDW'(k) || done !== 1'b1) begin failures++; $display("FAIL all4_done%0d got=%b/%0d exp=1/%0d", k, done, done_id, k); end
        end
        checks++; if (q !== 6'h0F) begin failures++; $display("FAIL all4_q got=%h exp=%h", q, 6'h0F); end
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL all4_wrap got=%b exp=%b", gnt, 4'b0001); end
        req = 4'b0000;
        tick();
        tick();
        checks++; if (q !== 6'h0F) begin failures++; $display("FAIL all4_q_end got=%h exp=%h", q, 6'h0F); end
    endtask

    task automatic test_rr_ptr;
        do_reset();
        set_cmd(1, 4, 2'b00);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        tick();
        checks++; if (done_id !== 2'd1) begin failures++; $display("FAIL rr_setup got=%0d exp=1", done_id); end
        set_cmd(0, 0, 2'b10);
        set_cmd(3, 1, 2'b10);
        req = 4'b1001;
        tick();
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL rr_first got=%b exp=%b", gnt, 4'b1000); end
        req = 4'b0001;
        tick();
        tick();
        checks++; if (q !== 6'h02) begin failures++; $display("FAIL rr_q3 got=%h exp=%h", q, 6'h02); end
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rr_second got=%b exp=%b", gnt, 4'b0001); end
        req = 4'b0000;
        tick();
        tick();
        checks++; if (q !== 6'h03) begin failures++; $display("FAIL rr_q0 got=%h exp=%h", q, 6'h03); end
    endtask

    task automatic test_error;
        do_reset();
        set_cmd(2, 5, 2'b10);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        tick();
        checks++; if (q !== 6'h20) begin failures++; $display("FAIL err_setup got=%h exp=%h", q, 6'h20); end
        set_cmd(2, 7, 2'b10);
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL err_gnt got=%b exp=%b", gnt, 4'b0100); end
        req = 4'b0000;
        tick();
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL err_done got=%b exp=1", done); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", err); end
        checks++; if (done_id !== 2'd2) begin failures++; $display("FAIL err_id got=%0d exp=2", done_id); end
        checks++; if (q !== 6'h20) begin failures++; $display("FAIL err_q got=%h exp=%h", q, 6'h20); end
        set_cmd(0, 1, 2'b10);
        req = 4'b0101;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL err_ptr_adv got=%b exp=%b", gnt, 4'b0001); end
        req = 4'b0000;
        tick();
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
        checks++; if (q !== 6'h22) begin failures++; $display("FAIL err_q_after got=%h exp=%h", q, 6'h22); end
    endtask

    task automatic test_reset_mid;
        int dones;
        do_reset();
        set_cmd(0, 1, 2'b10);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        tick();
        checks++; if (q !== 6'h02) begin failures++; $display("FAIL rmid_setup got=%h exp=%h", q, 6'h02); end
        set_cmd(0, 5, 2'b10);
        req = 4'b0001;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_in_master got=%b exp=1", busy); end
        reset = 1'b1;
        req = 4'b0000;
        #1;
        checks++; if (q !== 6'h00) begin failures++; $display("FAIL rmid_q got=%h exp=%h", q, 6'h00); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rmid_gnt got=%b exp=%b", gnt, 4'b0000); end
        tick();
        #2 reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", dones); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0", busy); end
        checks++; if (q !== 6'h00) begin failures++; $display("FAIL rmid_q_end got=%h exp=%h", q, 6'h00); end
    endtask

    task automatic test_random;
        do_reset();
        mq = '0; mptr = 0; mleft = 0; mw = 0; midx = 0; mjk = 2'b00; mnew = 1'b0; merr = 1'b0;
        exp_gnt = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            model_step();
            tick();
            checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", cyc, gnt, exp_gnt); end
            checks++; if (done !== exp_done) begin failures++; $display("FAIL rnd_done c=%0d got=%b exp=%b", cyc, done, exp_done); end
            if (exp_done) begin
                checks++; if (done_id !== RIDW'(exp_id)) begin failures++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", cyc, done_id, exp_id); end
                checks++; if (err !== exp_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", cyc, err, exp_err); end
            end
            checks++; if (q !== mq) begin failures++; $display("FAIL rnd_q c=%0d got=%h exp=%h", cyc, q, mq); end
            checks++; if (busy !== (mleft != 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", cyc, busy, (mleft != 0)); end
            // Requesters may only change their command when idle or just granted.
            for (int r = 0; r < NREQ; r++) begin
                if (req[r] == 1'b0 || exp_gnt[r] == 1'b1) begin
                    req[r] = ($urandom_range(0, 99) < 45);
                    set_cmd(r, int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
                end
            end
        end
        req = '0;
    endtask

    initial begin
        req = '0; idx = '0; jk = '0; reset = 1'b0;
        test_reset();
        test_single();
        test_toggle();
        test_all_four();
        test_rr_ptr();
        test_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
